// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the iterative encryption core.
//   - FSM state encoding (aes_state_e)
//   - S-box and Rcon tables
//   - helpers: xtime, sbox, rcon_f, sub_word, rot_word, mix_column, f_nr
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_READY  = 3'd2,
    ST_RUN    = 3'd3,
    ST_HOLD   = 3'd4
  } aes_state_e;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constants; entry 0 is used for the first expanded round word.
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] idx;
    idx = 8'hff - b;
    return SBOX_TBL[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon_f(input logic [3:0] idx);
    if (idx < 4'd10) begin
      return RCON[idx];
    end else begin
      return 8'h00;
    end
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // One state column: [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8).
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic int f_nr(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES encryption round.
//   state_i [127:0]  round input, byte 0 in bits [127:120]
//   rk_i    [127:0]  round key
//   last_i           final round: MixColumns is bypassed
//   state_o [127:0]  round output
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [127:0] sb_s;
  logic [127:0] sr_s;
  logic [127:0] mc_s;

  for (genvar k = 0; k < 16; k++) begin : g_sub
    assign sb_s[127-8*k -: 8] = sbox(state_i[127-8*k -: 8]);
  end

  // State byte 4*c+r is row r of column c; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_s[127-8*(4*c+r) -: 8] = sb_s[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mc_s[127-32*c -: 32] = mix_column(sr_s[127-32*c -: 32]);
  end

  assign state_o = last_i ? (sr_s ^ rk_i) : (mc_s ^ rk_i);

endmodule

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128/192/256 encryption core, one round per clock.
// The key is expanded once into an internal word store, then any number of
// blocks are encrypted under it, one block in flight at a time.
//   clk, rst_n           clock, asynchronous active-low reset
//   key_valid/key_ready  key channel, key [KEY_BITS-1:0]
//   in_valid/in_ready    plaintext channel, datain [127:0]
//   out_valid/out_ready  ciphertext channel, dataout [127:0]
//   busy                 key expansion or encryption in progress
// Optional build macro AES_KEY_ZEROIZE_EN adds input zeroize, which clears the
// key store, cipher state and output and returns the FSM to IDLE.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS      = 128,
  parameter bit BIG_ENDIAN_IO = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        datain,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        dataout,
  output logic                busy
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = f_nr(KEY_BITS);
  localparam int NW = 4 * (NR + 1);
  localparam int RW = $clog2(NR + 1);
  localparam int WW = $clog2(NW);

  localparam logic [RW-1:0] NR_R    = RW'(NR);
  localparam logic [RW-1:0] DONE_R  = RW'(NR + 1);
  localparam logic [RW-1:0] ONE_R   = RW'(1);
  localparam logic [WW-1:0] NK_W    = WW'(NK);
  localparam logic [WW-1:0] LAST_W  = WW'(NW - 1);
  localparam logic [WW-1:0] ONE_W   = WW'(1);
  localparam logic [2:0]    KM_LAST = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_enc_iter: KEY_BITS must be 128, 192 or 256");
  end

  aes_state_e          fsm_q, fsm_d;
  logic [127:0]        blk_q, blk_d;
  logic [RW-1:0]       rnd_q, rnd_d;
  logic [WW-1:0]       widx_q, widx_d;
  logic [2:0]          kmod_q, kmod_d;
  logic [3:0]          rcon_idx_q, rcon_idx_d;
  logic                out_valid_q, out_valid_d;
  logic [127:0]        dataout_q, dataout_d;
  logic [31:0]         w_q [NW];
  logic [31:0]         w_d [NW];
  logic [31:0]         w_upd_s [NW];

  logic [KEY_BITS-1:0] key_s;
  logic [127:0]        din_s;
  logic [31:0]         kw_s [NK];
  logic [31:0]         kprev_s, kfar_s, ktemp_s, knew_s;
  logic                key_load_s, kexp_we_s;
  logic                key_ready_s, in_ready_s, busy_s;
  logic [RW-1:0]       rk_sel_s;
  logic [WW-1:0]       rk_base_s;
  logic [127:0]        rk_s, rk0_s, round_s;
  logic                last_s;

  // Port byte order: internal datapath is always FIPS-197 (byte 0 at MSB).
  if (BIG_ENDIAN_IO) begin : g_be
    assign key_s   = key;
    assign din_s   = datain;
    assign dataout = dataout_q;
  end else begin : g_le
    for (genvar b = 0; b < KEY_BITS / 8; b++) begin : g_kb
      assign key_s[8*b +: 8] = key[KEY_BITS-8-8*b +: 8];
    end
    for (genvar b = 0; b < 16; b++) begin : g_db
      assign din_s[8*b +: 8]   = datain[120-8*b +: 8];
      assign dataout[8*b +: 8] = dataout_q[120-8*b +: 8];
    end
  end

  for (genvar j = 0; j < NK; j++) begin : g_kw
    assign kw_s[j] = key_s[KEY_BITS-32-32*j +: 32];
  end

  // Key schedule: next word from w[i-1] and w[i-NK].
  assign kprev_s = w_q[widx_q - ONE_W];
  assign kfar_s  = w_q[widx_q - NK_W];
  assign knew_s  = kfar_s ^ ktemp_s;

  // Key schedule temp word; kmod_q tracks i mod NK without a divider.
  always_comb begin
    ktemp_s = kprev_s;
    if (kmod_q == 3'd0) begin
      ktemp_s = sub_word(rot_word(kprev_s)) ^ {rcon_f(rcon_idx_q), 24'h000000};
    end else if (NK == 8 && kmod_q == 3'd4) begin
      ktemp_s = sub_word(kprev_s);
    end else begin
      ktemp_s = kprev_s;
    end
  end

  // Per-word store update: key load fills w[0..NK-1], expansion one word per cycle.
  for (genvar j = 0; j < NW; j++) begin : g_w
    if (j < NK) begin : g_key_word
      assign w_upd_s[j] = key_load_s ? kw_s[j] : w_q[j];
    end else begin : g_exp_word
      assign w_upd_s[j] = (kexp_we_s && widx_q == WW'(j)) ? knew_s : w_q[j];
    end
`ifdef AES_KEY_ZEROIZE_EN
    assign w_d[j] = zeroize ? 32'h0000_0000 : w_upd_s[j];
    // Key store word, cleared by reset and zeroize.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        w_q[j] <= 32'h0000_0000;
      end else begin
        w_q[j] <= w_d[j];
      end
    end
`else
    assign w_d[j] = w_upd_s[j];
    // Key store word; deliberately not reset, a fresh key must be loaded anyway.
    always_ff @(posedge clk) begin
      w_q[j] <= w_d[j];
    end
`endif
  end

  // Round key for the current round; clamped during the output cycle.
  assign rk_sel_s  = (rnd_q > NR_R) ? NR_R : rnd_q;
  assign rk_base_s = WW'({rk_sel_s, 2'b00});
  assign rk_s      = {w_q[rk_base_s], w_q[rk_base_s + WW'(1)],
                      w_q[rk_base_s + WW'(2)], w_q[rk_base_s + WW'(3)]};
  assign rk0_s     = {w_q[0], w_q[1], w_q[2], w_q[3]};
  assign last_s    = (rnd_q == NR_R);

  aes_round u_round (
    .state_i (blk_q),
    .rk_i    (rk_s),
    .last_i  (last_s),
    .state_o (round_s)
  );

  // FSM next state, datapath next values and handshake decode.
  always_comb begin
    fsm_d       = fsm_q;
    blk_d       = blk_q;
    rnd_d       = rnd_q;
    widx_d      = widx_q;
    kmod_d      = kmod_q;
    rcon_idx_d  = rcon_idx_q;
    out_valid_d = out_valid_q;
    dataout_d   = dataout_q;
    key_load_s  = 1'b0;
    kexp_we_s   = 1'b0;
    key_ready_s = 1'b0;
    in_ready_s  = 1'b0;
    busy_s      = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        key_ready_s = 1'b1;
        if (key_valid) begin
          key_load_s = 1'b1;
          widx_d     = NK_W;
          kmod_d     = 3'd0;
          rcon_idx_d = 4'd0;
          fsm_d      = ST_KEYEXP;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_KEYEXP: begin
        busy_s    = 1'b1;
        kexp_we_s = 1'b1;
        widx_d    = widx_q + ONE_W;
        kmod_d    = (kmod_q == KM_LAST) ? 3'd0 : kmod_q + 3'd1;
        if (kmod_q == 3'd0) begin
          rcon_idx_d = rcon_idx_q + 4'd1;
        end else begin
          rcon_idx_d = rcon_idx_q;
        end
        if (widx_q == LAST_W) begin
          fsm_d = ST_READY;
        end else begin
          fsm_d = ST_KEYEXP;
        end
      end
      ST_READY: begin
        in_ready_s  = 1'b1;
        // A block presented in the same cycle as a key has priority.
        key_ready_s = !in_valid;
        if (in_valid) begin
          blk_d = din_s ^ rk0_s;
          rnd_d = ONE_R;
          fsm_d = ST_RUN;
        end else if (key_valid) begin
          key_load_s = 1'b1;
          widx_d     = NK_W;
          kmod_d     = 3'd0;
          rcon_idx_d = 4'd0;
          fsm_d      = ST_KEYEXP;
        end else begin
          fsm_d = ST_READY;
        end
      end
      ST_RUN: begin
        busy_s = 1'b1;
        // Rounds 1..NR update blk_q; the extra cycle registers the result.
        if (rnd_q == DONE_R) begin
          dataout_d   = blk_q;
          out_valid_d = 1'b1;
          fsm_d       = ST_HOLD;
        end else begin
          blk_d = round_s;
          rnd_d = rnd_q + ONE_R;
          fsm_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = ST_READY;
        end else begin
          fsm_d = ST_HOLD;
        end
      end
      default: begin
        fsm_d       = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
`ifdef AES_KEY_ZEROIZE_EN
    if (zeroize) begin
      fsm_d       = ST_IDLE;
      blk_d       = '0;
      out_valid_d = 1'b0;
      dataout_d   = '0;
      key_load_s  = 1'b0;
      kexp_we_s   = 1'b0;
    end else begin
      fsm_d = fsm_d;
    end
`endif
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      blk_q       <= '0;
      rnd_q       <= '0;
      widx_q      <= '0;
      kmod_q      <= 3'd0;
      rcon_idx_q  <= 4'd0;
      out_valid_q <= 1'b0;
      dataout_q   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      blk_q       <= blk_d;
      rnd_q       <= rnd_d;
      widx_q      <= widx_d;
      kmod_q      <= kmod_d;
      rcon_idx_q  <= rcon_idx_d;
      out_valid_q <= out_valid_d;
      dataout_q   <= dataout_d;
    end
  end

  assign key_ready = key_ready_s;
  assign in_ready  = in_ready_s;
  assign busy      = busy_s;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: directed-vector bench for aes_enc_iter.
// Three instances (128/192/256-bit keys) share clock and reset; expected
// ciphertexts are the FIPS-197 example vectors.
module tb_aes_enc_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   key_valid, key_ready, in_valid, in_ready;
  logic [2:0]   out_valid, out_ready, busy;
  logic [255:0] key_v   [3];
  logic [127:0] datain  [3];
  logic [127:0] dataout [3];
`ifdef AES_KEY_ZEROIZE_EN
  logic [2:0]   zeroize;
`endif
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_B = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY_A128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KB = 128 + 64 * g;
    aes_enc_iter #(.KEY_BITS(KB), .BIG_ENDIAN_IO(1'b1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef AES_KEY_ZEROIZE_EN
      .zeroize   (zeroize[g]),
`endif
      .key_valid (key_valid[g]),
      .key_ready (key_ready[g]),
      .key       (key_v[g][KB-1:0]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .datain    (datain[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .dataout   (dataout[g]),
      .busy      (busy[g])
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a key once key_ready is high, then time the expansion.
  task automatic load_key(input logic [1:0] g, input logic [255:0] k, input int exp_cyc, input string tag);
    int n = 0;
    while (!key_ready[g] && n < 300) begin
      step();
      n++;
    end
    key_v[g]     = k;
    key_valid[g] = 1'b1;
    step();
    key_valid[g] = 1'b0;
    check_eq({tag, " busy_kexp"}, 128'(busy[g]), 128'(1'b1));
    n = 0;
    while (!key_ready[g] && n < 300) begin
      n++;
      step();
    end
    check_eq({tag, " kexp_cycles"}, 128'(n), 128'(exp_cyc));
    check_eq({tag, " in_ready_after_kexp"}, 128'(in_ready[g]), 128'(1'b1));
  endtask

  // Encrypt one block, check latency and ciphertext, stall hold cycles, then drain.
  task automatic encrypt(input logic [1:0] g, input logic [127:0] pt, input logic [127:0] ct,
                         input int lat, input int hold, input string tag);
    int n = 0;
    while (!in_ready[g] && n < 300) begin
      step();
      n++;
    end
    datain[g]   = pt;
    in_valid[g] = 1'b1;
    step();
    in_valid[g] = 1'b0;
    n = 0;
    while (!out_valid[g] && n < 300) begin
      n++;
      step();
    end
    check_eq({tag, " latency"}, 128'(n), 128'(lat));
    check_eq({tag, " dataout"}, dataout[g], ct);
    for (int h = 0; h < hold; h++) begin
      step();
      check_eq({tag, " hold_dataout"}, dataout[g], ct);
      check_eq({tag, " hold_valid"}, 128'(out_valid[g]), 128'(1'b1));
      check_eq({tag, " hold_in_ready"}, 128'(in_ready[g]), 128'(1'b0));
    end
    out_ready[g] = 1'b1;
    step();
    out_ready[g] = 1'b0;
    check_eq({tag, " valid_dropped"}, 128'(out_valid[g]), 128'(1'b0));
  endtask

  initial begin
    logic [255:0] kv [3];
    logic [127:0] cv [3];
    int n;
    kv[0] = KEY_A128;
    kv[1] = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    kv[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    cv[0] = CT_A128;
    cv[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    cv[2] = 128'h8ea2b7ca516745bfeafc49904b496089;

    rst_n     = 1'b0;
    key_valid = 3'b000;
    in_valid  = 3'b000;
    out_ready = 3'b000;
`ifdef AES_KEY_ZEROIZE_EN
    zeroize   = 3'b000;
`endif
    for (int g = 0; g < 3; g++) begin
      key_v[g]  = '0;
      datain[g] = '0;
    end
    step();
    step();
    for (int g = 0; g < 3; g++) begin
      check_eq("rst key_ready", 128'(key_ready[g]), 128'(1'b1));
      check_eq("rst in_ready", 128'(in_ready[g]), 128'(1'b0));
      check_eq("rst out_valid", 128'(out_valid[g]), 128'(1'b0));
      check_eq("rst busy", 128'(busy[g]), 128'(1'b0));
      check_eq("rst dataout", dataout[g], 128'h0);
    end
    rst_n = 1'b1;
    step();

    // FIPS-197 appendix C vectors for all three key sizes.
    for (int g = 0; g < 3; g++) begin
      load_key(2'(g), kv[g], 40 + 6 * g, $sformatf("fips_k%0d", 128 + 64 * g));
      encrypt(2'(g), PT_A, cv[g], 11 + 2 * g, 0, $sformatf("fips_e%0d", 128 + 64 * g));
    end

    // Two blocks under one key, the second stalled on out_ready.
    load_key(2'd0, KEY_B, 40, "b2b_key");
    encrypt(2'd0, PT_B, CT_B, 11, 0, "b2b_blk1");
    encrypt(2'd0, PT_B, CT_B, 11, 5, "b2b_blk2");

    // Key and block together in READY: block wins under the old key.
    key_v[0]     = KEY_A128;
    key_valid[0] = 1'b1;
    datain[0]    = PT_B;
    in_valid[0]  = 1'b1;
    #1;
    check_eq("collide key_ready", 128'(key_ready[0]), 128'(1'b0));
    step();
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 300) begin
      n++;
      step();
    end
    check_eq("collide latency", 128'(n), 128'(11));
    check_eq("collide old_key_ct", dataout[0], CT_B);
    check_eq("collide hold_key_ready", 128'(key_ready[0]), 128'(1'b0));
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    check_eq("collide ready_again", 128'(key_ready[0]), 128'(1'b1));
    load_key(2'd0, KEY_A128, 40, "collide_newkey");
    encrypt(2'd0, PT_A, CT_A128, 11, 0, "collide_newct");

    // Reset while the block is at round 5.
    datain[0]   = PT_A;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("midrst busy_before", 128'(busy[0]), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    check_eq("midrst busy", 128'(busy[0]), 128'(1'b0));
    check_eq("midrst out_valid", 128'(out_valid[0]), 128'(1'b0));
    check_eq("midrst in_ready", 128'(in_ready[0]), 128'(1'b0));
    check_eq("midrst key_ready", 128'(key_ready[0]), 128'(1'b1));
    check_eq("midrst dataout", dataout[0], 128'h0);
    step();
    rst_n = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("postrst in_ready", 128'(in_ready[0]), 128'(1'b0));
      check_eq("postrst busy", 128'(busy[0]), 128'(1'b0));
    end
    in_valid[0] = 1'b0;
    load_key(2'd0, KEY_B, 40, "postrst_key");
    encrypt(2'd0, PT_B, CT_B, 11, 0, "postrst_enc");

`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize while holding a result.
    datain[0]   = PT_B;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 300) begin
      n++;
      step();
    end
    check_eq("zero hold_valid", 128'(out_valid[0]), 128'(1'b1));
    zeroize[0] = 1'b1;
    step();
    zeroize[0] = 1'b0;
    check_eq("zero out_valid", 128'(out_valid[0]), 128'(1'b0));
    check_eq("zero key_ready", 128'(key_ready[0]), 128'(1'b1));
    check_eq("zero in_ready", 128'(in_ready[0]), 128'(1'b0));
    for (int i = 0; i < 3; i++) step();
    check_eq("zero in_ready_later", 128'(in_ready[0]), 128'(1'b0));
    load_key(2'd0, KEY_B, 40, "zero_key");
    encrypt(2'd0, PT_B, CT_B, 11, 0, "zero_enc");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit in case a handshake never completes.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
